// File: rtl/rx_bit_timer.sv
// USB receive bit-timing controller.
// Aligns to the first D+ edge after reception starts, then issues one
// shift_enable strobe per bit period and a byte_received pulse after every
// BITS_PER_BYTE strobes. All outputs are decoded from registers only.
// Optional feature macro: RX_TIMER_RESYNC_EN (re-centre the bit counter on
// every D+ edge seen while running).
module rx_bit_timer #(
   parameter int unsigned CLKS_PER_BIT  = 8,
   parameter int unsigned SAMPLE_POINT  = 3,
   parameter int unsigned BITS_PER_BYTE = 8
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             rcving,
   input  logic                             d_edge,
   output logic                             shift_enable,
   output logic                             byte_received,
   output logic [$clog2(BITS_PER_BYTE)-1:0] bit_idx
);

   localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
   localparam int unsigned IdxW = $clog2(BITS_PER_BYTE);

   localparam logic [CntW-1:0] CntLast   = CntW'(CLKS_PER_BIT - 1);
   localparam logic [CntW-1:0] CntSample = CntW'(SAMPLE_POINT);
   localparam logic [IdxW-1:0] IdxLast   = IdxW'(BITS_PER_BYTE - 1);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StAlign = 2'd1;
   localparam logic [1:0] StRun   = 2'd2;

   logic [1:0]      state_q, state_d;
   logic [CntW-1:0] clk_cnt_q, clk_cnt_d;
   logic [IdxW-1:0] bit_idx_q, bit_idx_d;
   logic            byte_rcvd_q, byte_rcvd_d;
   logic            strobe;

   // Sample strobe: decoded purely from state and counter registers
   always_comb begin
      strobe = (state_q == StRun) && (clk_cnt_q == CntSample);
   end

   // Next-state logic; dropping rcving overrides everything and also
   // cancels a byte_received that would otherwise fire next cycle
   always_comb begin
      state_d     = state_q;
      clk_cnt_d   = clk_cnt_q;
      bit_idx_d   = bit_idx_q;
      byte_rcvd_d = 1'b0;
      if (!rcving) begin
         state_d   = StIdle;
         clk_cnt_d = '0;
         bit_idx_d = '0;
      end else begin
         case (state_q)
            StIdle: begin
               clk_cnt_d = '0;
               bit_idx_d = '0;
               state_d   = StAlign;
            end
            StAlign: begin
               if (d_edge) begin
                  state_d   = StRun;
                  clk_cnt_d = '0;
                  bit_idx_d = '0;
               end
            end
            StRun: begin
               clk_cnt_d = (clk_cnt_q == CntLast) ? '0 : clk_cnt_q + CntW'(1);
               if (strobe) begin
                  if (bit_idx_q == IdxLast) begin
                     bit_idx_d   = '0;
                     byte_rcvd_d = 1'b1;
                  end else begin
                     bit_idx_d = bit_idx_q + IdxW'(1);
                  end
               end
`ifdef RX_TIMER_RESYNC_EN
               // Edge restarts the bit period; a coincident strobe still counts
               if (d_edge) begin
                  clk_cnt_d = '0;
               end
`endif
            end
            default: begin
               state_d   = StIdle;
               clk_cnt_d = '0;
               bit_idx_d = '0;
            end
         endcase
      end
   end

   // State registers with synchronous active-high reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         clk_cnt_q   <= '0;
         bit_idx_q   <= '0;
         byte_rcvd_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         clk_cnt_q   <= clk_cnt_d;
         bit_idx_q   <= bit_idx_d;
         byte_rcvd_q <= byte_rcvd_d;
      end
   end

   assign shift_enable  = strobe;
   assign byte_received = byte_rcvd_q;
   assign bit_idx       = bit_idx_q;

endmodule

// File: tb/tb_rx_bit_timer.sv
// Testbench for rx_bit_timer at default parameters.
// A per-cycle vector table covers reset, IDLE and ALIGN entry and the first
// strobe; longer sequences use a scoreboard of expected strobe and
// byte_received cycle numbers, checked by a monitor on the falling edge.
module tb_rx_bit_timer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rcving = 1'b0;
   logic       d_edge = 1'b0;
   logic       shift_enable;
   logic       byte_received;
   logic [2:0] bit_idx;

   int cyc = 0;
   int n_tests = 0;
   int n_fail = 0;
   bit sb_on = 1'b0;
   int exp_se_q[$];
   int exp_br_q[$];

   rx_bit_timer #(
      .CLKS_PER_BIT (8),
      .SAMPLE_POINT (3),
      .BITS_PER_BYTE(8)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .rcving       (rcving),
      .d_edge       (d_edge),
      .shift_enable (shift_enable),
      .byte_received(byte_received),
      .bit_idx      (bit_idx)
   );

   always #5 clk = ~clk;

   // Cycle number: during the cycle after the k-th rising edge, cyc == k
   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard monitor: every strobe/byte pulse must match the queue head
   always @(negedge clk) begin
      if (sb_on) begin
         if (shift_enable) begin
            n_tests++;
            if (exp_se_q.size() == 0) begin
               n_fail++;
               $display("FAIL strobe_unexpected: strobe at cycle %0d, expected none", cyc);
            end else begin
               if (exp_se_q[0] != cyc) begin
                  n_fail++;
                  $display("FAIL strobe_time: strobe at cycle %0d, expected cycle %0d",
                           cyc, exp_se_q[0]);
               end
               void'(exp_se_q.pop_front());
            end
         end else if (exp_se_q.size() > 0 && exp_se_q[0] <= cyc) begin
            n_tests++;
            n_fail++;
            $display("FAIL strobe_missing: no strobe at cycle %0d, expected cycle %0d",
                     cyc, exp_se_q[0]);
            void'(exp_se_q.pop_front());
         end
         if (byte_received) begin
            n_tests++;
            if (exp_br_q.size() == 0) begin
               n_fail++;
               $display("FAIL byte_unexpected: byte_received at cycle %0d, expected none", cyc);
            end else begin
               if (exp_br_q[0] != cyc) begin
                  n_fail++;
                  $display("FAIL byte_time: byte_received at cycle %0d, expected cycle %0d",
                           cyc, exp_br_q[0]);
               end
               void'(exp_br_q.pop_front());
            end
         end else if (exp_br_q.size() > 0 && exp_br_q[0] <= cyc) begin
            n_tests++;
            n_fail++;
            $display("FAIL byte_missing: no byte_received at cycle %0d, expected cycle %0d",
                     cyc, exp_br_q[0]);
            void'(exp_br_q.pop_front());
         end
      end
   end

   typedef struct {
      logic       rst;
      logic       rcving;
      logic       d_edge;
      logic       chk;
      logic       exp_se;
      logic       exp_br;
      logic [2:0] exp_idx;
   } vec_t;

   function automatic vec_t mk(input int r, input int c, input int d, input int k,
                               input int se, input int br, input int idx);
      vec_t v;
      v.rst     = r[0];
      v.rcving  = c[0];
      v.d_edge  = d[0];
      v.chk     = k[0];
      v.exp_se  = se[0];
      v.exp_br  = br[0];
      v.exp_idx = idx[2:0];
      return v;
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) tick(1);
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic do_reset();
      rst    = 1'b1;
      rcving = 1'b0;
      d_edge = 1'b0;
      tick(2);
      rst = 1'b0;
   endtask

   // Drive the aligning edge in the current cycle and return its cycle number
   task automatic align(output int t);
      d_edge = 1'b1;
      t = cyc;
      tick(1);
      d_edge = 1'b0;
   endtask

   task automatic push_strobes(input int t, input int n);
      for (int k = 0; k < n; k++) exp_se_q.push_back(t + 4 + 8 * k);
   endtask

   task automatic finish_scn(input string name);
      tick(3);
      check({name, "_strobes_left"}, exp_se_q.size(), 0);
      check({name, "_bytes_left"}, exp_br_q.size(), 0);
      exp_se_q.delete();
      exp_br_q.delete();
   endtask

   vec_t tbl[18];

   initial begin
      int t;
      int t2;

      // rst, rcving, d_edge, chk, exp shift_enable, exp byte_received, exp bit_idx
      tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0);
      tbl[1]  = mk(1, 0, 0, 1, 0, 0, 0);
      tbl[2]  = mk(0, 0, 0, 1, 0, 0, 0);
      tbl[3]  = mk(0, 0, 1, 1, 0, 0, 0);  // edge with rcving low: ignored
      tbl[4]  = mk(0, 1, 1, 1, 0, 0, 0);  // edge in IDLE: ignored
      tbl[5]  = mk(0, 1, 0, 1, 0, 0, 0);  // ALIGN
      tbl[6]  = mk(0, 1, 0, 1, 0, 0, 0);
      tbl[7]  = mk(0, 1, 1, 1, 0, 0, 0);  // aligning edge
      tbl[8]  = mk(0, 1, 0, 1, 0, 0, 0);  // RUN, clk_cnt 0
      tbl[9]  = mk(0, 1, 0, 1, 0, 0, 0);
      tbl[10] = mk(0, 1, 0, 1, 0, 0, 0);
      tbl[11] = mk(0, 1, 0, 1, 1, 0, 0);  // first strobe, 4 cycles after edge
      tbl[12] = mk(0, 1, 0, 1, 0, 0, 1);
      tbl[13] = mk(0, 0, 0, 1, 0, 0, 1);  // drop rcving
      tbl[14] = mk(0, 1, 0, 1, 0, 0, 0);  // IDLE, cleared
      tbl[15] = mk(0, 1, 0, 1, 0, 0, 0);  // ALIGN
      tbl[16] = mk(0, 1, 0, 1, 0, 0, 0);
      tbl[17] = mk(0, 1, 0, 1, 0, 0, 0);

      tick(1);
      for (int i = 0; i < 18; i++) begin
         rst    = tbl[i].rst;
         rcving = tbl[i].rcving;
         d_edge = tbl[i].d_edge;
         if (tbl[i].chk) begin
            check($sformatf("vec%0d_{se,br,idx}", i),
                  int'({shift_enable, byte_received, bit_idx}),
                  int'({tbl[i].exp_se, tbl[i].exp_br, tbl[i].exp_idx}));
         end
         tick(1);
      end

      // Idle after reset: no strobe for 20 cycles, stray edges ignored
      do_reset();
      sb_on = 1'b1;
      for (int i = 0; i < 20; i++) begin
         d_edge = (i % 3 == 0);
         tick(1);
      end
      d_edge = 1'b0;
      check("idle_idx", int'(bit_idx), 0);
      finish_scn("idle");

      // Two back-to-back bytes: 16 strobes at 8-cycle spacing, 2 byte pulses
      do_reset();
      rcving = 1'b1;
      tick(2);
      align(t);
      push_strobes(t, 16);
      exp_br_q.push_back(t + 61);
      exp_br_q.push_back(t + 125);
      wait_until(t + 4);
      check("b2b_idx_first", int'(bit_idx), 0);
      wait_until(t + 45);
      check("b2b_idx_after6", int'(bit_idx), 6);
      wait_until(t + 62);
      check("b2b_idx_wrap", int'(bit_idx), 0);
      wait_until(t + 69);
      check("b2b_idx_byte2", int'(bit_idx), 1);
      wait_until(t + 128);
      rcving = 1'b0;
      tick(2);
      check("b2b_idx_idle", int'(bit_idx), 0);
      finish_scn("b2b");

      // Extra edge 10 cycles after alignment
      do_reset();
      rcving = 1'b1;
      tick(2);
      align(t);
`ifdef RX_TIMER_RESYNC_EN
      exp_se_q.push_back(t + 4);
      exp_se_q.push_back(t + 14);
      exp_se_q.push_back(t + 22);
`else
      push_strobes(t, 3);
`endif
      wait_until(t + 10);
      d_edge = 1'b1;
      tick(1);
      d_edge = 1'b0;
      wait_until(t + 23);
      check("resync_idx", int'(bit_idx), 3);
      wait_until(t + 24);
      rcving = 1'b0;
      tick(1);
      finish_scn("resync");

      // rcving dropped during the 8th strobe: byte pulse suppressed, realign
      do_reset();
      rcving = 1'b1;
      tick(2);
      align(t);
      push_strobes(t, 8);
      wait_until(t + 60);
      rcving = 1'b0;
      tick(1);
      check("drop_byte", int'(byte_received), 0);
      check("drop_idx", int'(bit_idx), 0);
      rcving = 1'b1;
      tick(30);
      align(t2);
      push_strobes(t2, 1);
      wait_until(t2 + 5);
      check("drop_realign_idx", int'(bit_idx), 1);
      rcving = 1'b0;
      tick(2);
      finish_scn("drop");

      // Reset mid-byte with bit_idx at 5
      do_reset();
      rcving = 1'b1;
      tick(2);
      align(t);
      push_strobes(t, 5);
      wait_until(t + 38);
      check("midrst_idx_before", int'(bit_idx), 5);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check("midrst_se", int'(shift_enable), 0);
      check("midrst_br", int'(byte_received), 0);
      check("midrst_idx", int'(bit_idx), 0);
      tick(20);
      rcving = 1'b0;
      tick(1);
      finish_scn("midrst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
